// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types, constants and helpers for the base-B
//                up/down digit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Largest radix a digit may take; a digit is never wider than 4 bits.
  localparam int MAX_BASE = 16;

  // Count direction, matches the encoding of the 'up' input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Force a loaded digit value into the legal range 0..base-1 so the
  // counting logic never sees an out-of-range digit.
  function automatic logic [3:0] digit_clamp(input logic [3:0] value, input int base);
    if (int'(value) >= base) begin
      return 4'(base - 1);
    end
    return value;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/b_updown_digit.sv
`default_nettype none
// ============================================================================
//  Module      : b_updown_digit
//  Description : One base-BASE up/down counter digit with parallel load and
//                carry/borrow out. Chains through ei/eu.
//  Revision    : 1.0 - initial release
// ============================================================================
module b_updown_digit
  import counter_pkg::*;
#(
  parameter  int BASE = 3,
  localparam int W    = $clog2(BASE)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ei,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         eu
);

  localparam logic [W-1:0] MAX_DIGIT = W'(BASE - 1);

  if (BASE < 2 || BASE > MAX_BASE) begin : g_bad_base
    $error("b_updown_digit: BASE must be in 2..16");
  end

  dir_t dir;
  logic at_wrap;

  assign dir = dir_t'(up);

  // The digit is at its wrap value for the current direction.
  assign at_wrap = (dir == DIR_UP) ? (q == MAX_DIGIT) : (q == '0);
  assign eu      = ei & at_wrap;

  // Digit register: reset > load > count > hold. Wrap-around keeps q < BASE.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= W'(digit_clamp(4'(d), BASE));
    end else if (ei) begin
      if (dir == DIR_UP) begin
        q <= (q == MAX_DIGIT) ? '0 : q + W'(1);
      end else begin
        q <= (q == '0) ? MAX_DIGIT : q - W'(1);
      end
    end
  end

endmodule : b_updown_digit
`default_nettype wire

// File: rtl/nb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : nb_updown_counter
//  Description : N_DIGITS-digit base-BASE synchronous up/down counter with
//                parallel load, terminal count and cascade carry/borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module nb_updown_counter
  import counter_pkg::*;
#(
  parameter  int N_DIGITS = 4,
  parameter  int BASE     = 3,
  localparam int W        = $clog2(BASE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ei,
  input  logic                  up,
  input  logic                  load,
  input  logic [N_DIGITS*W-1:0] d,
  output logic [N_DIGITS*W-1:0] q,
  output logic                  eu,
  output logic                  tc
);

  localparam logic [W-1:0] MAX_DIGIT = W'(BASE - 1);

  if (BASE < 2 || BASE > MAX_BASE || N_DIGITS < 1) begin : g_bad_params
    $error("nb_updown_counter: BASE must be in 2..16 and N_DIGITS >= 1");
  end

  // carry[i] enables digit i; carry[N_DIGITS] leaves the block as eu.
  logic [N_DIGITS:0]   carry;
  logic [N_DIGITS-1:0] digit_wrap;

  assign carry[0] = ei;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    b_updown_digit #(
      .BASE (BASE)
    ) u_digit (
      .clock (clock),
      .reset (reset),
      .ei    (carry[i]),
      .up    (up),
      .load  (load),
      .d     (d[i*W +: W]),
      .q     (q[i*W +: W]),
      .eu    (carry[i+1])
    );

    // Per-digit terminal flag, independent of the enable chain.
    assign digit_wrap[i] = up ? (q[i*W +: W] == MAX_DIGIT) : (q[i*W +: W] == '0);
  end

  // Whole counter at its wrap value; eu equals ei & tc through the chain.
  assign tc = &digit_wrap;
  assign eu = carry[N_DIGITS];

endmodule : nb_updown_counter
`default_nettype wire

// File: tb/tb_nb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nb_updown_counter
//  Description : Directed self-checking bench for nb_updown_counter: a
//                default 4-digit base-3 instance and two chained 2-digit
//                decimal instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nb_updown_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default instance, N=4, B=3 (2 bits per digit).
  logic       reset, ei, up, load;
  logic [7:0] d, q;
  logic       eu, tc;

  nb_updown_counter u_dut (
    .clock (clock), .reset (reset), .ei (ei), .up (up), .load (load),
    .d (d), .q (q), .eu (eu), .tc (tc)
  );

  // Two chained instances, N=2, B=10 each, form a 4-digit decimal counter.
  logic       c_reset, c_ei, c_up, c_load;
  logic [7:0] c_d_lo, c_d_hi, c_q_lo, c_q_hi;
  logic       c_eu_lo, c_eu_hi, c_tc_lo, c_tc_hi;

  nb_updown_counter #(.N_DIGITS(2), .BASE(10)) u_lo (
    .clock (clock), .reset (c_reset), .ei (c_ei), .up (c_up), .load (c_load),
    .d (c_d_lo), .q (c_q_lo), .eu (c_eu_lo), .tc (c_tc_lo)
  );

  nb_updown_counter #(.N_DIGITS(2), .BASE(10)) u_hi (
    .clock (clock), .reset (c_reset), .ei (c_eu_lo), .up (c_up), .load (c_load),
    .d (c_d_hi), .q (c_q_hi), .eu (c_eu_hi), .tc (c_tc_hi)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pack an integer 0..80 as four base-3 digits, 2 bits each, LSD at [1:0].
  function automatic logic [7:0] enc3(input int v);
    logic [7:0] r;
    int         t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*2 +: 2] = 2'(t % 3);
      t = t / 3;
    end
    return r;
  endfunction

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; ei = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    c_reset = 1'b1; c_ei = 1'b0; c_up = 1'b1; c_load = 1'b0;
    c_d_lo = '0; c_d_hi = '0;
    step();

    // Reset state and direction-dependent tc.
    check("reset_q", 32'(q), 32'h00);
    check("reset_tc_up", 32'(tc), 32'd0);
    up = 1'b0; #1;
    check("reset_tc_down", 32'(tc), 32'd1);
    check("reset_eu_ei0", 32'(eu), 32'd0);

    // Full up count 0..80 in base 3, eu only at 2222.
    up = 1'b1; reset = 1'b0; ei = 1'b1; #1;
    for (int k = 0; k <= 80; k++) begin
      check($sformatf("up_q_%0d", k), 32'(q), 32'(enc3(k)));
      check($sformatf("up_eu_%0d", k), 32'(eu), (k == 80) ? 32'd1 : 32'd0);
      step();
    end
    check("up_wrap_q", 32'(q), 32'h00);
    check("up_wrap_eu", 32'(eu), 32'd0);

    // Down from reset: tc/eu immediately, then 2222, 2221, 2220.
    reset = 1'b1; step(); reset = 1'b0; up = 1'b0; ei = 1'b1; #1;
    check("down_tc0", 32'(tc), 32'd1);
    check("down_eu0", 32'(eu), 32'd1);
    step(); check("down_q1", 32'(q), 32'b10_10_10_10);
    step(); check("down_q2", 32'(q), 32'b10_10_10_01);
    step(); check("down_q3", 32'(q), 32'b10_10_10_00);

    // Load with clamp; ei in the same cycle is ignored.
    up = 1'b1; ei = 1'b1; load = 1'b1; d = {2'd3, 2'd1, 2'd0, 2'd2};
    step(); check("load_clamp", 32'(q), 32'b10_01_00_10);

    // Hold when ei=0.
    load = 1'b0; ei = 1'b0; step();
    check("hold_q", 32'(q), 32'b10_01_00_10);

    // Reset wins over load.
    load = 1'b1; d = {2'd1, 2'd2, 2'd1, 2'd1}; step();
    check("load_1211", 32'(q), 32'b01_10_01_01);
    reset = 1'b1; d = 8'b10_10_10_10; ei = 1'b1; step();
    check("reset_over_load", 32'(q), 32'h00);

    // Direction change at 0122: decrements, no carry.
    reset = 1'b0; load = 1'b1; ei = 1'b0; d = {2'd0, 2'd1, 2'd2, 2'd2}; step();
    check("load_0122", 32'(q), 32'b00_01_10_10);
    load = 1'b0; up = 1'b1; ei = 1'b1; #1;
    check("dir_eu_up", 32'(eu), 32'd0);
    up = 1'b0; #1;
    check("dir_eu_down", 32'(eu), 32'd0);
    step(); check("dir_q", 32'(q), 32'b00_01_10_01);
    ei = 1'b0;

    // Chained decimal counter: load 9997 with a clamped digit, count through 9999.
    c_reset = 1'b0; c_load = 1'b1; c_d_hi = 8'h99; c_d_lo = 8'h9F; step();
    check("c_load_clamp", {16'd0, c_q_hi, c_q_lo}, 32'h9999);
    c_d_lo = 8'h97; step();
    check("c_load_9997", {16'd0, c_q_hi, c_q_lo}, 32'h9997);
    c_load = 1'b0; c_ei = 1'b1; c_up = 1'b1; #1;
    check("c_eu_9997", 32'(c_eu_hi), 32'd0);
    step(); check("c_q_9998", {16'd0, c_q_hi, c_q_lo}, 32'h9998);
    step(); check("c_q_9999", {16'd0, c_q_hi, c_q_lo}, 32'h9999);
    check("c_eu_9999", 32'(c_eu_hi), 32'd1);
    check("c_tc_hi_9999", 32'(c_tc_hi), 32'd1);
    step(); check("c_q_0000", {16'd0, c_q_hi, c_q_lo}, 32'h0000);
    check("c_eu_0000", 32'(c_eu_hi), 32'd0);
    step(); check("c_q_0001", {16'd0, c_q_hi, c_q_lo}, 32'h0001);

    // Chained borrow: 0001 -> 0000 -> 9999.
    c_up = 1'b0; step();
    check("c_dn_0000", {16'd0, c_q_hi, c_q_lo}, 32'h0000);
    check("c_dn_eu", 32'(c_eu_hi), 32'd1);
    step(); check("c_dn_9999", {16'd0, c_q_hi, c_q_lo}, 32'h9999);
    c_load = 1'b1; c_d_hi = 8'h00; c_d_lo = 8'h90; step();
    check("c_load_0090", {16'd0, c_q_hi, c_q_lo}, 32'h0090);
    c_load = 1'b0; step();
    check("c_dn_0089", {16'd0, c_q_hi, c_q_lo}, 32'h0089);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nb_updown_counter
`default_nettype wire
